stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 144 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch key front-end and mode FSM.
// Debounced start/stop, lap and clear keys drive run/hold/clr.
module stopwatch_ctrl #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_ss,
  input  logic       key_lap,
  input  logic       key_clr,
  output logic       run,
  output logic       clr,
  output logic       hold,
  output logic [1:0] state
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;

  localparam logic [19:0] DEB_LAST =
    20'(DEB_CYCLES - 1);

  localparam int K_SS  = 0;
  localparam int K_LAP = 1;
  localparam int K_CLR = 2;

  logic [2:0] keys;
  logic [2:0] sy1;
  logic [2:0] sy2;
  logic [2:0] ev;

  assign keys = {key_clr, key_lap, key_ss};

  // two-flop synchronizers, idle high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sy1 <= '1;
      sy2 <= '1;
    end else begin
      sy1 <= keys;
      sy2 <= sy1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic [19:0] cnt;
    logic        stb;
    logic        evq;
    logic        hit;
    logic        fall;

    assign hit  = (cnt == DEB_LAST);
    assign fall = stb & ~sy2[g] & hit;
    assign ev[g] = evq;

    // debounce counter, stable level and press pulse
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
        stb <= 1'b1;
        evq <= 1'b0;
      end else begin
        evq <= fall;
        if (sy2[g] == stb) begin
          cnt <= '0;
        end else if (hit) begin
          stb <= sy2[g];
          cnt <= '0;
        end else begin
          cnt <= cnt + 20'd1;
        end
      end
    end
  end

  logic       w_ss;
  logic       w_clr;
  logic       w_lap;
  logic [1:0] st_n;
  logic       hold_n;
  logic       clr_n;

  // ss beats clr beats lap; losers are dropped
  assign w_ss  = ev[K_SS];
  assign w_clr = ev[K_CLR] & ~ev[K_SS];
  assign w_lap = ev[K_LAP] & ~ev[K_SS]
               & ~ev[K_CLR];

  // next-state decode
  always_comb begin
    st_n   = state;
    hold_n = hold;
    clr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          w_ss:  st_n  = RUN;
          w_clr: clr_n = 1'b1;
          default: ;
        endcase
      end
      RUN: begin
        unique case (1'b1)
          w_ss:  st_n   = PAUSE;
          w_lap: hold_n = ~hold;
          default: ;
        endcase
      end
      PAUSE: begin
        unique case (1'b1)
          w_ss: st_n = RUN;
          w_clr: begin
            st_n   = IDLE;
            hold_n = 1'b0;
            clr_n  = 1'b1;
          end
          default: ;
        endcase
      end
      default: begin
        st_n   = IDLE;
        hold_n = 1'b0;
      end
    endcase
    if (st_n == IDLE) hold_n = 1'b0;
  end

  // registered mode outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      run   <= 1'b0;
      hold  <= 1'b0;
      clr   <= 1'b0;
    end else begin
      state <= st_n;
      run   <= (st_n == RUN);
      hold  <= hold_n;
      clr   <= clr_n;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl.
// Expected output changes queued on key press, popped on change.
module tb_stopwatch_ctrl;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_ss = 1'b1;
  logic       key_lap = 1'b1;
  logic       key_clr = 1'b1;
  logic       run;
  logic       clr;
  logic       hold;
  logic [1:0] state;

  stopwatch_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk(clk),
    .rst(rst),
    .key_ss(key_ss),
    .key_lap(key_lap),
    .key_clr(key_clr),
    .run(run),
    .clr(clr),
    .hold(hold),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] val;
    int         t0;
    int         lo;
    int         hi;
    bit         prim;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         lat_ref = -1;
  bit         mon_en = 1'b0;
  logic [4:0] prev = '0;
  logic [1:0] m_st = 2'b00;
  logic       m_hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d",
               tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [4:0] v, input int t0,
                      input int lo, input bit prim,
                      input string tag);
    exp_t e;
    e.val  = v;
    e.t0   = t0;
    e.lo   = lo;
    e.hi   = lo + 4;
    e.prim = prim;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // reference behaviour of one accepted event set
  task automatic step(input bit s, input bit c, input bit l,
                      input int t0, input string tag);
    logic [1:0] ns;
    logic       nh;
    logic       np;
    logic [4:0] ov;
    logic [4:0] nv;
    ns = m_st;
    nh = m_hold;
    np = 1'b0;
    if (s) begin
      ns = (m_st == 2'b01) ? 2'b10 : 2'b01;
    end else if (c) begin
      if (m_st == 2'b00) np = 1'b1;
      else if (m_st == 2'b10) begin
        ns = 2'b00;
        nh = 1'b0;
        np = 1'b1;
      end
    end else if (l) begin
      if (m_st == 2'b01) nh = ~m_hold;
    end
    ov = {m_st, m_st == 2'b01, m_hold, 1'b0};
    nv = {ns, ns == 2'b01, nh, np};
    if (nv != ov) push(nv, t0, DEB, 1'b1, tag);
    if (np)
      push({ns, ns == 2'b01, nh, 1'b0}, t0, DEB + 1,
           1'b0, {tag, "_clr_end"});
    m_st   = ns;
    m_hold = nh;
  endtask

  // output-change monitor
  always @(negedge clk) begin
    logic [4:0] cur;
    exp_t       e;
    int         lat;
    cur = {state, run, hold, clr};
    if (mon_en && cur !== prev) begin
      if (sb.size() == 0) begin
        chk("unexp_out", 32'(cur), 32'(prev));
      end else begin
        e = sb.pop_front();
        lat = cyc - e.t0;
        chk(e.tag, 32'(cur), 32'(e.val));
        chk({e.tag, "_lat_ok"},
            32'(lat >= e.lo && lat <= e.hi), 32'd1);
        if (e.prim) begin
          if (lat_ref < 0) lat_ref = lat;
          else chk("lat_same", 32'(lat), 32'(lat_ref));
        end
      end
    end
    prev = cur;
  end

  task automatic chk_out(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(m_st));
    chk({tag, "_run"}, 32'(run), 32'(m_st == 2'b01));
    chk({tag, "_hold"}, 32'(hold), 32'(m_hold));
    chk({tag, "_clr"}, 32'(clr), 32'd0);
  endtask

  task automatic press(input bit s, input bit c,
                       input bit l, input string tag);
    @(negedge clk);
    if (s) key_ss = 1'b0;
    if (c) key_clr = 1'b0;
    if (l) key_lap = 1'b0;
    step(s, c, l, cyc, tag);
    repeat (20) @(negedge clk);
    chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
    key_ss  = 1'b1;
    key_clr = 1'b1;
    key_lap = 1'b1;
    repeat (DEB + 8) @(negedge clk);
    chk_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired @cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_out("reset");
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    @(negedge clk);
    key_ss = 1'b0;
    repeat (2) @(negedge clk);
    key_ss = 1'b1;
    repeat (DEB + 10) @(negedge clk);
    chk_out("glitch");

    press(1'b1, 1'b0, 1'b0, "ss_start");
    press(1'b0, 1'b1, 1'b0, "clr_in_run");
    press(1'b0, 1'b0, 1'b1, "lap1");
    press(1'b0, 1'b0, 1'b1, "lap2");
    press(1'b0, 1'b0, 1'b1, "lap3");
    press(1'b1, 1'b0, 1'b0, "ss_pause");
    press(1'b0, 1'b1, 1'b0, "clr_pause");
    press(1'b0, 1'b0, 1'b1, "lap_idle");
    press(1'b0, 1'b1, 1'b0, "clr_idle");
    press(1'b1, 1'b0, 1'b0, "ss_run2");
    press(1'b0, 1'b0, 1'b1, "lap4");
    press(1'b1, 1'b0, 1'b0, "ss_pause2");
    press(1'b1, 1'b1, 1'b0, "ss_clr_same");

    @(negedge clk);
    key_ss = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_run", 32'(run), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_hold", 32'(hold), 32'd0);
    chk("arst_clr", 32'(clr), 32'd0);
    sb.delete();
    m_st = 2'b00;
    m_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, cyc, "post_rst");
    repeat (20) @(negedge clk);
    chk("post_rst_drain", 32'(sb.size()), 32'd0);
    key_ss = 1'b1;
    repeat (DEB + 8) @(negedge clk);
    chk_out("post_rst");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
